int_seq: RTL and testbench
==========================

Name: int_seq

Overview:
- Interrupt entry/return sequencer between the interrupt priority block and the CPU core.
- Consumes the latched request (REQ) and its vector address (ADDRInt).
- At an instruction boundary it stalls the core, pushes PC then SR, clears GIE, fetches the vector and loads PC.
- On a decoded RETI it pops SR then PC and issues the one-cycle RTI pulse that releases the priority block.

Parameters:
GIE_BIT, 3, bit index of GIE in the status register
DATA_W, 16, data/address width (only 16 supported)

Ports:
CLK  in  1  system clock, rising edge
RESET_N  in  1  asynchronous active-low reset
REQ  in  1  pending interrupt from the priority block
ADDRInt  in  16  vector address for the pending interrupt
INSTR_DONE  in  1  core is at an instruction boundary this cycle
RETI_DEC  in  1  instruction just completed is RETI (valid with INSTR_DONE)
PC_IN  in  16  current PC (return address)
SR_IN  in  16  current status register
SP_IN  in  16  current stack pointer
MEM_RDY  in  1  memory completes the current transfer this cycle
MEM_RDATA  in  16  read data, valid when MEM_RDY=1
MEM_REQ  out  1  memory transfer request
MEM_WE  out  1  1=write, 0=read
MEM_ADDR  out  16  transfer address
MEM_WDATA  out  16  write data
PC_OUT  out  16  new PC value
PC_WE  out  1  PC write strobe, one cycle
SR_OUT  out  16  new SR value
SR_WE  out  1  SR write strobe, one cycle
SP_OUT  out  16  new SP value
SP_WE  out  1  SP write strobe, one cycle
CPU_HOLD  out  1  core stalled while the sequence runs
RTI  out  1  one-cycle return-from-interrupt pulse to the priority block
IN_ISR  out  1  1 from vector load until RTI

Behaviour:
- States: IDLE, PUSH_PC, PUSH_SR, FETCH_VEC, POP_SR, POP_PC, RTI_OUT.
- Reset (RESET_N=0, async):
  - State goes to IDLE.
  - All outputs are 0.
  - Working registers (sp_q, pc_q, sr_q, vec_q) are cleared.
  - Reset mid-sequence abandons the sequence with no further strobes.
- IDLE, at a rising edge with INSTR_DONE=1:
  - RETI_DEC=1 → POP_SR. Latch sp_q = SP_IN & 16'hFFFE. RETI takes priority over REQ in the same cycle.
  - else REQ=1 and SR_IN[GIE_BIT]=1 → PUSH_PC. Latch pc_q=PC_IN, sr_q=SR_IN, vec_q=ADDRInt & 16'hFFFE, sp_q=(SP_IN & 16'hFFFE)-2 (mod 2^16, 16'h0000 wraps to 16'hFFFE).
  - REQ=1 with GIE=0 → stay in IDLE; the request stays pending upstream.
- CPU_HOLD = (state != IDLE), combinational.
- Memory handshake:
  - In every memory state, MEM_REQ=1 and MEM_ADDR/MEM_WE/MEM_WDATA are held stable until a rising edge with MEM_RDY=1.
  - That edge completes the transfer and advances the state. MEM_RDATA is sampled on the same edge.
  - MEM_REQ=0 in IDLE and RTI_OUT.
- PUSH_PC: write pc_q to sp_q. On completion: SP_OUT=sp_q, SP_WE=1 for one cycle; sp_q -= 2 → PUSH_SR.
- PUSH_SR: write sr_q to sp_q. On completion:
  - SP_OUT=sp_q, SP_WE=1.
  - SR_OUT = sr_q with bit GIE_BIT cleared, SR_WE=1.
  - → FETCH_VEC.
- FETCH_VEC: read vec_q. On completion: PC_OUT=MEM_RDATA, PC_WE=1, IN_ISR←1 → IDLE.
- POP_SR: read sp_q. On completion: SR_OUT=MEM_RDATA, SR_WE=1, sp_q += 2, SP_OUT=new sp_q, SP_WE=1 → POP_PC.
- POP_PC: read sp_q. On completion: PC_OUT=MEM_RDATA, PC_WE=1, sp_q += 2, SP_OUT=new sp_q, SP_WE=1 → RTI_OUT.
- RTI_OUT: RTI=1 for exactly one cycle, IN_ISR←0 → IDLE.
- Strobe timing: all *_WE strobes are registered, asserted in the cycle after the completing edge, and last one cycle.
- Latency with MEM_RDY tied 1:
  - Entry: 3 cycles of CPU_HOLD; PC_WE in cycle 4 after detection.
  - Return: 3 cycles of CPU_HOLD; RTI asserted in the 3rd.
- Stack arithmetic is modulo 2^16: pop from 16'hFFFE yields 16'h0000.
- A new REQ while IN_ISR=1 with GIE re-enabled by software starts a nested entry.
- RETI_DEC with IN_ISR=0 still performs the pop sequence and RTI pulse.

Test Plan:
- Basic entry: SP_IN=16'h0400, PC_IN=16'h1234, SR_IN=16'h0008, ADDRInt=16'hFFFA, mem[FFFA]=16'h8000, RDY=1 → writes 1234@03FE then 0008@03FC; SR_OUT=0000; PC_OUT=8000; SP_OUT=03FC; IN_ISR=1.
- Return: after the entry above, RETI_DEC+INSTR_DONE → reads 03FC then 03FE; SR_OUT=0008; PC_OUT=1234; SP_OUT=0400; RTI high exactly 1 cycle; IN_ISR=0.
- GIE masked: REQ=1, SR_IN=0 → no MEM_REQ, CPU_HOLD stays 0 for 10 cycles. Then SR_IN=0008 → entry starts.
- Wait states: MEM_RDY=0 for 3 cycles in each state → MEM_ADDR/WDATA stable, no strobes until MEM_RDY=1; results identical to basic entry.
- Simultaneous events and wrap: RETI_DEC=1 with REQ=1 in the same cycle → pop first. SP_IN=16'h0000 entry → pushes at FFFE/FFFC.
- Reset mid-sequence: RESET_N low during PUSH_SR → all outputs 0 immediately; after release, state IDLE with no stray SR_WE/PC_WE.

Source files
------------

// File: rtl/int_seq_if.sv
// Signal bundle between the interrupt sequencer, the priority block,
// the CPU core and the memory port.
interface int_seq_if;
    // priority block
    logic        REQ;
    logic [15:0] ADDRInt;
    logic        RTI;
    // core status
    logic        INSTR_DONE;
    logic        RETI_DEC;
    logic [15:0] PC_IN;
    logic [15:0] SR_IN;
    logic [15:0] SP_IN;
    // memory port
    logic        MEM_RDY;
    logic [15:0] MEM_RDATA;
    logic        MEM_REQ;
    logic        MEM_WE;
    logic [15:0] MEM_ADDR;
    logic [15:0] MEM_WDATA;
    // core register updates
    logic [15:0] PC_OUT;
    logic        PC_WE;
    logic [15:0] SR_OUT;
    logic        SR_WE;
    logic [15:0] SP_OUT;
    logic        SP_WE;
    logic        CPU_HOLD;
    logic        IN_ISR;

    // sequencer side
    modport master (
        input  REQ, ADDRInt, INSTR_DONE, RETI_DEC, PC_IN, SR_IN, SP_IN,
               MEM_RDY, MEM_RDATA,
        output RTI, MEM_REQ, MEM_WE, MEM_ADDR, MEM_WDATA,
               PC_OUT, PC_WE, SR_OUT, SR_WE, SP_OUT, SP_WE, CPU_HOLD, IN_ISR
    );

    // environment side (priority block, core, memory)
    modport slave (
        output REQ, ADDRInt, INSTR_DONE, RETI_DEC, PC_IN, SR_IN, SP_IN,
               MEM_RDY, MEM_RDATA,
        input  RTI, MEM_REQ, MEM_WE, MEM_ADDR, MEM_WDATA,
               PC_OUT, PC_WE, SR_OUT, SR_WE, SP_OUT, SP_WE, CPU_HOLD, IN_ISR
    );
endinterface

// File: rtl/int_seq.sv
// Interrupt entry/return sequencer.
//
// state       | meaning
// ------------+-----------------------------------------------------
// IDLE        | core runs; watch for RETI or an enabled request
// PUSH_PC     | write return PC to the stack
// PUSH_SR     | write status register to the stack, clear GIE
// FETCH_VEC   | read the vector and load PC
// POP_SR      | read saved SR from the stack
// POP_PC      | read saved PC from the stack
// RTI_OUT     | one-cycle release pulse to the priority block
module int_seq #(
    parameter int GIE_BIT = 3,
    parameter int DATA_W  = 16
) (
    input  logic       CLK,
    input  logic       RESET_N,
    int_seq_if.master  bus
);

    typedef enum logic [2:0] {
        S_IDLE, S_PUSH_PC, S_PUSH_SR, S_FETCH_VEC, S_POP_SR, S_POP_PC, S_RTI_OUT
    } state_t;

    localparam logic [DATA_W-1:0] ALIGN    = ~DATA_W'(1);
    localparam logic [DATA_W-1:0] TWO      = DATA_W'(2);
    localparam logic [DATA_W-1:0] GIE_MASK = DATA_W'(1) << GIE_BIT;

    state_t            state_q, state_d;
    logic [DATA_W-1:0] sp_q, sp_d, pc_q, pc_d, sr_q, sr_d, vec_q, vec_d;
    logic [DATA_W-1:0] pc_out_q, pc_out_d, sr_out_q, sr_out_d, sp_out_q, sp_out_d;
    logic              pc_we_q, pc_we_d, sr_we_q, sr_we_d, sp_we_q, sp_we_d;
    logic              in_isr_q, in_isr_d;
    logic              mem_req, mem_we;
    logic [DATA_W-1:0] mem_addr, mem_wdata;

    // State, working registers and registered core strobes.
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            state_q  <= S_IDLE;
            sp_q     <= '0;
            pc_q     <= '0;
            sr_q     <= '0;
            vec_q    <= '0;
            pc_out_q <= '0;
            sr_out_q <= '0;
            sp_out_q <= '0;
            pc_we_q  <= 1'b0;
            sr_we_q  <= 1'b0;
            sp_we_q  <= 1'b0;
            in_isr_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            sp_q     <= sp_d;
            pc_q     <= pc_d;
            sr_q     <= sr_d;
            vec_q    <= vec_d;
            pc_out_q <= pc_out_d;
            sr_out_q <= sr_out_d;
            sp_out_q <= sp_out_d;
            pc_we_q  <= pc_we_d;
            sr_we_q  <= sr_we_d;
            sp_we_q  <= sp_we_d;
            in_isr_q <= in_isr_d;
        end
    end

    // Next state, memory request and strobe values; a memory state only
    // advances on an edge where MEM_RDY completes its transfer.
    always_comb begin
        state_d   = state_q;
        sp_d      = sp_q;
        pc_d      = pc_q;
        sr_d      = sr_q;
        vec_d     = vec_q;
        pc_out_d  = pc_out_q;
        sr_out_d  = sr_out_q;
        sp_out_d  = sp_out_q;
        pc_we_d   = 1'b0;
        sr_we_d   = 1'b0;
        sp_we_d   = 1'b0;
        in_isr_d  = in_isr_q;
        mem_req   = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        case (state_q)
            S_IDLE: begin
                if (bus.INSTR_DONE) begin
                    if (bus.RETI_DEC) begin
                        state_d = S_POP_SR;
                        sp_d    = bus.SP_IN & ALIGN;
                    end else if (bus.REQ && bus.SR_IN[GIE_BIT]) begin
                        state_d = S_PUSH_PC;
                        pc_d    = bus.PC_IN;
                        sr_d    = bus.SR_IN;
                        vec_d   = bus.ADDRInt & ALIGN;
                        sp_d    = (bus.SP_IN & ALIGN) - TWO;
                    end
                end
            end
            S_PUSH_PC: begin
                mem_req   = 1'b1;
                mem_we    = 1'b1;
                mem_addr  = sp_q;
                mem_wdata = pc_q;
                if (bus.MEM_RDY) begin
                    sp_out_d = sp_q;
                    sp_we_d  = 1'b1;
                    sp_d     = sp_q - TWO;
                    state_d  = S_PUSH_SR;
                end
            end
            S_PUSH_SR: begin
                mem_req   = 1'b1;
                mem_we    = 1'b1;
                mem_addr  = sp_q;
                mem_wdata = sr_q;
                if (bus.MEM_RDY) begin
                    sp_out_d = sp_q;
                    sp_we_d  = 1'b1;
                    sr_out_d = sr_q & ~GIE_MASK;
                    sr_we_d  = 1'b1;
                    state_d  = S_FETCH_VEC;
                end
            end
            S_FETCH_VEC: begin
                mem_req  = 1'b1;
                mem_addr = vec_q;
                if (bus.MEM_RDY) begin
                    pc_out_d = bus.MEM_RDATA;
                    pc_we_d  = 1'b1;
                    in_isr_d = 1'b1;
                    state_d  = S_IDLE;
                end
            end
            S_POP_SR: begin
                mem_req  = 1'b1;
                mem_addr = sp_q;
                if (bus.MEM_RDY) begin
                    sr_out_d = bus.MEM_RDATA;
                    sr_we_d  = 1'b1;
                    sp_d     = sp_q + TWO;
                    sp_out_d = sp_q + TWO;
                    sp_we_d  = 1'b1;
                    state_d  = S_POP_PC;
                end
            end
            S_POP_PC: begin
                mem_req  = 1'b1;
                mem_addr = sp_q;
                if (bus.MEM_RDY) begin
                    pc_out_d = bus.MEM_RDATA;
                    pc_we_d  = 1'b1;
                    sp_d     = sp_q + TWO;
                    sp_out_d = sp_q + TWO;
                    sp_we_d  = 1'b1;
                    state_d  = S_RTI_OUT;
                end
            end
            S_RTI_OUT: begin
                in_isr_d = 1'b0;
                state_d  = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign bus.MEM_REQ   = mem_req;
    assign bus.MEM_WE    = mem_we;
    assign bus.MEM_ADDR  = mem_addr;
    assign bus.MEM_WDATA = mem_wdata;
    assign bus.PC_OUT    = pc_out_q;
    assign bus.PC_WE     = pc_we_q;
    assign bus.SR_OUT    = sr_out_q;
    assign bus.SR_WE     = sr_we_q;
    assign bus.SP_OUT    = sp_out_q;
    assign bus.SP_WE     = sp_we_q;
    assign bus.IN_ISR    = in_isr_q;
    assign bus.CPU_HOLD  = (state_q != S_IDLE);
    assign bus.RTI       = (state_q == S_RTI_OUT);

endmodule

// File: tb/tb_int_seq.sv
// Bench for int_seq: a memory responder plus a transaction-level model
// that predicts the stack traffic and core register updates per event.
module tb_int_seq;

    logic CLK = 1'b0;
    logic RESET_N;

    int_seq_if bus();

    int_seq #(.GIE_BIT(3), .DATA_W(16)) dut (
        .CLK     (CLK),
        .RESET_N (RESET_N),
        .bus     (bus)
    );

    always #5 CLK = ~CLK;

    typedef struct packed {
        logic        pc_we;
        logic [15:0] pc;
        logic        sr_we;
        logic [15:0] sr;
        logic        sp_we;
        logic [15:0] sp;
        logic        rti;
        logic        in_isr;
    } obs_t;

    typedef struct packed {
        logic        we;
        logic [15:0] addr;
        logic [15:0] wdata;
    } txn_t;

    int          n_vec = 0;
    int          n_err = 0;
    logic [15:0] mem [65536];
    obs_t        exp_obs[$];
    txn_t        exp_txn[$];
    logic        m_in_isr = 1'b0;
    logic [15:0] m_sp = 16'h0400;
    int          rdy_mode = 0;
    int          wait_cnt;
    int          rti_cnt = 0;
    logic        prev_pend;
    txn_t        prev_t, cur_t, want_t;
    obs_t        act_o;
    logic        rdy;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        n_vec++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, req);
        end
    endtask

    // Memory responder and per-cycle comparison against the model queues.
    always @(negedge CLK) begin
        if (!RESET_N) begin
            bus.MEM_RDY   = 1'b0;
            bus.MEM_RDATA = 16'h0;
            prev_pend     = 1'b0;
            wait_cnt      = 0;
        end else begin
            if (bus.PC_WE || bus.SR_WE || bus.SP_WE || bus.RTI) begin
                if (bus.RTI) rti_cnt++;
                act_o.pc_we  = bus.PC_WE;
                act_o.pc     = bus.PC_WE ? bus.PC_OUT : 16'h0;
                act_o.sr_we  = bus.SR_WE;
                act_o.sr     = bus.SR_WE ? bus.SR_OUT : 16'h0;
                act_o.sp_we  = bus.SP_WE;
                act_o.sp     = bus.SP_WE ? bus.SP_OUT : 16'h0;
                act_o.rti    = bus.RTI;
                act_o.in_isr = bus.IN_ISR;
                if (exp_obs.size() == 0) begin
                    n_vec++; n_err++;
                    $display("FAIL unexpected_strobe: got %0h expected none", act_o);
                end else begin
                    check("strobe", 64'(act_o), 64'(exp_obs.pop_front()));
                end
            end
            cur_t.we    = bus.MEM_WE;
            cur_t.addr  = bus.MEM_ADDR;
            cur_t.wdata = bus.MEM_WE ? bus.MEM_WDATA : 16'h0;
            if (prev_pend && bus.MEM_REQ) check("mem_hold", 64'(cur_t), 64'(prev_t));
            if (rdy_mode == 2) begin
                if (!bus.MEM_REQ) begin rdy = 1'b0; wait_cnt = 0; end
                else if (wait_cnt < 3) begin rdy = 1'b0; wait_cnt++; end
                else begin rdy = 1'b1; wait_cnt = 0; end
            end else if (rdy_mode == 1) begin
                rdy = 1'($urandom_range(0, 1));
            end else begin
                rdy = 1'b1;
            end
            if (bus.MEM_REQ && rdy) begin
                if (exp_txn.size() == 0) begin
                    n_vec++; n_err++;
                    $display("FAIL unexpected_mem: got %0h expected none", cur_t);
                end else begin
                    want_t = exp_txn.pop_front();
                    check("mem_txn", 64'(cur_t), 64'(want_t));
                end
                if (bus.MEM_WE) mem[bus.MEM_ADDR] = bus.MEM_WDATA;
            end
            prev_pend     = bus.MEM_REQ && !rdy;
            prev_t        = cur_t;
            bus.MEM_RDY   = rdy;
            bus.MEM_RDATA = rdy ? mem[bus.MEM_ADDR] : 16'($urandom);
        end
    end

    // Present one instruction boundary and record what it must cause.
    task automatic launch(input bit reti, input bit req, input logic [15:0] sr,
                          input logic [15:0] pc, input logic [15:0] sp, input logic [15:0] addr);
        logic [15:0] s, v, vd;
        @(posedge CLK); #2;
        bus.INSTR_DONE = 1'b1;
        bus.RETI_DEC   = reti;
        bus.REQ        = req;
        bus.SR_IN      = sr;
        bus.PC_IN      = pc;
        bus.SP_IN      = sp;
        bus.ADDRInt    = addr;
        if (reti) begin
            s = {sp[15:1], 1'b0};
            exp_txn.push_back('{1'b0, s, 16'h0});
            exp_txn.push_back('{1'b0, s + 16'd2, 16'h0});
            exp_obs.push_back('{1'b0, 16'h0, 1'b1, mem[s], 1'b1, s + 16'd2, 1'b0, m_in_isr});
            exp_obs.push_back('{1'b1, mem[s + 16'd2], 1'b0, 16'h0, 1'b1, s + 16'd4, 1'b1, m_in_isr});
            m_in_isr = 1'b0;
            m_sp     = s + 16'd4;
        end else if (req && sr[3]) begin
            s  = {sp[15:1], 1'b0} - 16'd2;
            v  = {addr[15:1], 1'b0};
            vd = (v == s) ? pc : (v == s - 16'd2) ? sr : mem[v];
            exp_txn.push_back('{1'b1, s, pc});
            exp_txn.push_back('{1'b1, s - 16'd2, sr});
            exp_txn.push_back('{1'b0, v, 16'h0});
            exp_obs.push_back('{1'b0, 16'h0, 1'b0, 16'h0, 1'b1, s, 1'b0, m_in_isr});
            exp_obs.push_back('{1'b0, 16'h0, 1'b1, sr & 16'hFFF7, 1'b1, s - 16'd2, 1'b0, m_in_isr});
            exp_obs.push_back('{1'b1, vd, 1'b0, 16'h0, 1'b0, 16'h0, 1'b0, 1'b1});
            m_in_isr = 1'b1;
            m_sp     = s - 16'd2;
        end
        @(posedge CLK); #2;
        bus.INSTR_DONE = 1'b0;
        bus.RETI_DEC   = 1'b0;
        bus.REQ        = 1'b0;
        bus.PC_IN      = 16'($urandom);
        bus.SP_IN      = 16'($urandom);
        bus.SR_IN      = 16'($urandom);
        bus.ADDRInt    = 16'($urandom);
    endtask

    task automatic wait_idle(input int budget);
        int i;
        for (i = 0; i < budget; i++) begin
            @(posedge CLK); #2;
            if (exp_obs.size() == 0 && exp_txn.size() == 0 && !bus.CPU_HOLD) break;
        end
        n_vec++;
        if (i == budget) begin
            n_err++;
            $display("FAIL seq_timeout: %0d strobes and %0d transfers still pending after %0d cycles",
                     exp_obs.size(), exp_txn.size(), budget);
            exp_obs.delete();
            exp_txn.delete();
        end
    endtask

    task automatic check_all_zero(input string name);
        check({name, "_data"}, {bus.MEM_ADDR, bus.MEM_WDATA, bus.PC_OUT, bus.SR_OUT}, 64'h0);
        check({name, "_ctrl"}, 64'({bus.SP_OUT, bus.MEM_REQ, bus.MEM_WE, bus.PC_WE, bus.SR_WE,
                                    bus.SP_WE, bus.CPU_HOLD, bus.RTI, bus.IN_ISR}), 64'h0);
    endtask

    initial begin
        int i, r, rti0;
        logic [15:0] sp, sr;
        for (int k = 0; k < 65536; k++) mem[k] = 16'($urandom);
        RESET_N        = 1'b0;
        bus.INSTR_DONE = 1'b0;
        bus.RETI_DEC   = 1'b0;
        bus.REQ        = 1'b0;
        bus.SR_IN      = 16'h0;
        bus.PC_IN      = 16'h0;
        bus.SP_IN      = 16'h0;
        bus.ADDRInt    = 16'h0;
        repeat (3) @(posedge CLK);
        #2;
        check_all_zero("reset");
        RESET_N = 1'b1;

        // basic entry and return
        mem[16'hFFFA] = 16'h8000;
        launch(0, 1, 16'h0008, 16'h1234, 16'h0400, 16'hFFFA);
        wait_idle(100);
        check("entry_stk_pc", 64'(mem[16'h03FE]), 64'h1234);
        check("entry_stk_sr", 64'(mem[16'h03FC]), 64'h0008);
        check("entry_regs", {bus.PC_OUT, bus.SR_OUT, bus.SP_OUT, 15'h0, bus.IN_ISR},
              {16'h8000, 16'h0000, 16'h03FC, 16'h0001});
        rti0 = rti_cnt;
        launch(1, 0, 16'h0000, 16'h5555, 16'h03FC, 16'h0000);
        wait_idle(100);
        check("ret_regs", {bus.PC_OUT, bus.SR_OUT, bus.SP_OUT, 15'h0, bus.IN_ISR},
              {16'h1234, 16'h0008, 16'h0400, 16'h0000});
        check("ret_rti_once", 64'(rti_cnt - rti0), 64'd1);

        // request masked by GIE, then enabled
        @(posedge CLK); #2;
        bus.INSTR_DONE = 1'b1;
        bus.REQ        = 1'b1;
        bus.SR_IN      = 16'h0000;
        repeat (10) begin
            @(posedge CLK); #2;
            check("masked_idle", 64'({bus.CPU_HOLD, bus.MEM_REQ}), 64'h0);
        end
        launch(0, 1, 16'h0008, 16'h2222, 16'h0400, 16'hFFFA);
        wait_idle(100);
        check("unmask_pc", 64'(bus.PC_OUT), 64'h8000);
        launch(1, 0, 16'h0, 16'h0, m_sp, 16'h0);
        wait_idle(100);

        // wait states on every transfer
        rdy_mode = 2;
        launch(0, 1, 16'h0008, 16'h1234, 16'h0400, 16'hFFFA);
        wait_idle(200);
        check("ws_regs", {bus.PC_OUT, bus.SR_OUT, bus.SP_OUT, 15'h0, bus.IN_ISR},
              {16'h8000, 16'h0000, 16'h03FC, 16'h0001});
        launch(1, 0, 16'h0, 16'h0, 16'h03FC, 16'h0);
        wait_idle(200);
        check("ws_ret_pc", 64'(bus.PC_OUT), 64'h1234);
        rdy_mode = 0;

        // RETI and REQ together: the pop wins
        launch(0, 1, 16'h0808, 16'h4321, 16'h0200, 16'hFFFA);
        wait_idle(100);
        launch(1, 1, 16'h0808, 16'h7777, 16'h01FC, 16'hFFFA);
        wait_idle(100);
        check("simul_regs", {bus.PC_OUT, bus.SR_OUT, bus.SP_OUT, 16'h0},
              {16'h4321, 16'h0808, 16'h0200, 16'h0});

        // stack wrap
        mem[16'hFFF0] = 16'h1111;
        launch(0, 1, 16'h000F, 16'hABCD, 16'h0000, 16'hFFF0);
        wait_idle(100);
        check("wrap_stk", {mem[16'hFFFE], mem[16'hFFFC], bus.SR_OUT, bus.SP_OUT},
              {16'hABCD, 16'h000F, 16'h0007, 16'hFFFC});
        launch(1, 0, 16'h0, 16'h0, 16'hFFFC, 16'h0);
        wait_idle(100);
        check("wrap_pop", 64'({bus.PC_OUT, bus.SP_OUT}), 64'hABCD_0000);

        // reset in the middle of PUSH_SR
        rdy_mode = 2;
        launch(0, 1, 16'h0008, 16'h3333, 16'h0300, 16'hFFFA);
        for (i = 0; i < 50; i++) begin
            if (bus.MEM_REQ && bus.MEM_WE && bus.MEM_ADDR == 16'h02FC) break;
            @(posedge CLK); #2;
        end
        check("reach_push_sr", 64'(i < 50), 64'd1);
        @(negedge CLK); #1;
        RESET_N = 1'b0;
        #1;
        check_all_zero("mid_reset");
        exp_obs.delete();
        exp_txn.delete();
        m_in_isr = 1'b0;
        repeat (2) @(posedge CLK);
        #2;
        RESET_N  = 1'b1;
        rdy_mode = 0;
        repeat (8) begin
            @(posedge CLK); #2;
            check("post_reset_quiet", 64'({bus.PC_WE, bus.SR_WE, bus.SP_WE, bus.CPU_HOLD}), 64'h0);
        end

        // randomized entries, returns and nesting
        m_sp = 16'h0400;
        for (i = 0; i < 60; i++) begin
            rdy_mode = $urandom_range(0, 1);
            r = $urandom_range(0, 3);
            if (r == 0) begin
                sp = $urandom_range(0, 1) ? m_sp : 16'($urandom_range(16'h0100, 16'h7FFF));
                launch(1, 1'($urandom_range(0, 1)), 16'($urandom), 16'($urandom), sp, 16'($urandom));
            end else begin
                sp = (m_sp > 16'h0100 && m_sp < 16'h7FFF && $urandom_range(0, 1) == 1)
                     ? m_sp : 16'($urandom_range(16'h0400, 16'h7FFF));
                sr = 16'($urandom);
                sr[3] = ($urandom_range(0, 3) != 0);
                launch(0, 1'($urandom_range(0, 7) != 0), sr, 16'($urandom), sp,
                       16'hFF80 | 16'($urandom_range(0, 127)));
            end
            wait_idle(300);
        end

        repeat (3) @(posedge CLK);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation still running at %0t", $time);
        $fatal(1, "watchdog expired");
    end

endmodule
